// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and constants for the one-hot decoder family.
// Holds the controller state encoding plus the mode and scan-direction
// encodings seen on the i_mode / i_dir pins.
package decoder_pkg;

    // Controller states: outputs parked, direct decode, autonomous scan.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // i_mode encodings.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // i_dir encodings: which way the scan index moves on each step.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : decoder_pkg

// File: rtl/onehot_dec.sv
// onehot_dec: purely combinational SEL_W-to-2^SEL_W one-hot decoder.
// When en is low the output is all zeros; otherwise exactly bit sel is set.
// Generic replacement for the old fixed 3-to-8 decoder.
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] y
);

    // Set only the selected line; all lines low when disabled.
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule : onehot_dec

// File: rtl/decoder_nsel_scan.sv
// decoder_nsel_scan: registered SEL_W-to-2^SEL_W one-hot decoder with a
// direct-decode mode and an auto-scan mode (programmable dwell, up/down,
// wrap pulse). Every output is a flop; o_y is the decode of the next o_idx
// so o_y and o_idx always change together.
//
// Build option: define DECODER_OUT_ACTIVE_LOW_EN to make o_y active-low
// (idle/reset value all ones, selected line driven 0). o_idx and o_wrap
// keep the same polarity either way.
module decoder_nsel_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_mode,
    input  logic                  i_dir,
    input  logic [SEL_W-1:0]      i_a,
    input  logic [DWELL_W-1:0]    i_dwell,
    output logic [(2**SEL_W)-1:0] o_y,
    output logic [SEL_W-1:0]      o_idx,
    output logic                  o_wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

`ifdef DECODER_OUT_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] Y_OFF = {OUT_W{1'b1}};
`else
    localparam logic [OUT_W-1:0] Y_OFF = '0;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    logic [SEL_W-1:0]   idx_d;
    logic               wrap_d;
    logic               dec_en;
    logic [OUT_W-1:0]   y_hot;
    logic [OUT_W-1:0]   y_d;

    // Pick the state for this cycle: enable first, then mode.
    always_comb begin
        state_d = IDLE;
        if (i_en) begin
            case (i_mode)
                MODE_DIRECT: state_d = DIRECT;
                MODE_SCAN:   state_d = SCAN;
                default:     state_d = DIRECT;
            endcase
        end
    end

    // Work out the next index, dwell count and wrap flag for the chosen state.
    always_comb begin
        idx_d  = o_idx;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        dec_en = 1'b0;
        case (state_d)
            IDLE: begin
                // Index is held so software can still see where the scan stopped.
                cnt_d = '0;
            end
            DIRECT: begin
                idx_d  = i_a;
                cnt_d  = '0;
                dec_en = 1'b1;
            end
            SCAN: begin
                dec_en = 1'b1;
                if (state_q != SCAN) begin
                    // Entering scan (from IDLE or DIRECT) always restarts at i_a.
                    idx_d = i_a;
                    cnt_d = i_dwell;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
                end else begin
                    // Dwell expired: step, reload, and flag a modulo wrap.
                    // i_dir is only looked at here, so mid-dwell changes wait.
                    cnt_d = i_dwell;
                    if (i_dir == DIR_UP) begin
                        idx_d  = o_idx + {{(SEL_W-1){1'b0}}, 1'b1};
                        wrap_d = (o_idx == IDX_MAX);
                    end else begin
                        idx_d  = o_idx - {{(SEL_W-1){1'b0}}, 1'b1};
                        wrap_d = (o_idx == '0);
                    end
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_onehot_dec (
        .en  (dec_en),
        .sel (idx_d),
        .y   (y_hot)
    );

    // Output polarity applied ahead of the register so o_y stays glitch-free.
`ifdef DECODER_OUT_ACTIVE_LOW_EN
    assign y_d = ~y_hot;
`else
    assign y_d = y_hot;
`endif

    // State and all outputs are registered together; async reset to idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_idx   <= '0;
            o_wrap  <= 1'b0;
            o_y     <= Y_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_idx   <= idx_d;
            o_wrap  <= wrap_d;
            o_y     <= y_d;
        end
    end

endmodule : decoder_nsel_scan

// File: tb/tb_decoder_nsel_scan.sv
// tb_decoder_nsel_scan: directed-vector bench for decoder_nsel_scan
// (SEL_W=3, DWELL_W=4). The driver pushes the hand-computed output expected
// after each clock edge; a monitor pops and compares one cycle later.
module tb_decoder_nsel_scan;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 4;
    localparam int OUT_W   = 8;
    localparam int W       = OUT_W + SEL_W + 1;

`ifdef DECODER_OUT_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] Y_INV = {OUT_W{1'b1}};
`else
    localparam logic [OUT_W-1:0] Y_INV = '0;
`endif

    // Clock / reset and DUT pins.
    logic               i_clk   = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_en    = 1'b0;
    logic               i_mode  = 1'b0;
    logic               i_dir   = 1'b0;
    logic [SEL_W-1:0]   i_a     = '0;
    logic [DWELL_W-1:0] i_dwell = '0;
    logic [OUT_W-1:0]   o_y;
    logic [SEL_W-1:0]   o_idx;
    logic               o_wrap;

    // Scoreboard state.
    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    string       tag_q[$];

    always #5 i_clk = ~i_clk;

    decoder_nsel_scan #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_mode  (i_mode),
        .i_dir   (i_dir),
        .i_a     (i_a),
        .i_dwell (i_dwell),
        .o_y     (o_y),
        .o_idx   (o_idx),
        .o_wrap  (o_wrap)
    );

    // Compare the current DUT outputs against one packed expectation.
    task automatic compare(input string tag, input logic [W-1:0] exp);
        checks++;
        if ({o_y, o_idx, o_wrap} !== exp) begin
            errors++;
            $display("FAIL %s: got y=%h idx=%0d wrap=%0b, expected y=%h idx=%0d wrap=%0b",
                     tag, o_y, o_idx, o_wrap,
                     exp[W-1 -: OUT_W], exp[SEL_W:1], exp[0]);
        end
    endtask

    // Driver: apply one cycle of inputs and queue the outputs due after the edge.
    task automatic drv(input logic en, input logic mode, input logic dir,
                       input logic [SEL_W-1:0] a, input logic [DWELL_W-1:0] dw,
                       input logic [OUT_W-1:0] y, input logic [SEL_W-1:0] idx,
                       input logic wrap, input string tag);
        @(negedge i_clk);
        i_en    = en;
        i_mode  = mode;
        i_dir   = dir;
        i_a     = a;
        i_dwell = dw;
        exp_q.push_back({y ^ Y_INV, idx, wrap});
        tag_q.push_back(tag);
    endtask

    // Monitor: outputs are stable 1 time unit after each rising edge.
    initial begin
        logic [W-1:0] exp;
        string        tag;
        forever begin
            @(posedge i_clk);
            #1;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                compare(tag, exp);
            end
        end
    end

    logic [OUT_W-1:0] dir_tab [8];

    initial begin
        dir_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        // Reset values while held in reset.
        #2;
        compare("reset", {Y_INV, 3'd0, 1'b0});
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Direct decode sweep, one cycle latency.
        for (int a = 0; a < 8; a++) begin
            drv(1'b1, 1'b0, 1'b0, 3'(a), 4'd0, dir_tab[a], 3'(a), 1'b0, "direct_sweep");
        end

        // Scan up from 6, dwell 1: 6,6,7,7,0(wrap),0,1.
        drv(1'b1, 1'b1, 1'b0, 3'd6, 4'd1, 8'h40, 3'd6, 1'b0, "scan_up_entry");
        drv(1'b1, 1'b1, 1'b0, 3'd6, 4'd1, 8'h40, 3'd6, 1'b0, "scan_up_dwell6");
        drv(1'b1, 1'b1, 1'b0, 3'd6, 4'd1, 8'h80, 3'd7, 1'b0, "scan_up_step7");
        drv(1'b1, 1'b1, 1'b0, 3'd6, 4'd1, 8'h80, 3'd7, 1'b0, "scan_up_dwell7");
        drv(1'b1, 1'b1, 1'b0, 3'd6, 4'd1, 8'h01, 3'd0, 1'b1, "scan_up_wrap0");
        drv(1'b1, 1'b1, 1'b0, 3'd6, 4'd1, 8'h01, 3'd0, 1'b0, "scan_up_dwell0");
        drv(1'b1, 1'b1, 1'b0, 3'd6, 4'd1, 8'h02, 3'd1, 1'b0, "scan_up_step1");

        // Back to direct, then scan down from 1 with dwell 0: 1,0,7(wrap),6.
        drv(1'b1, 1'b0, 1'b1, 3'd1, 4'd0, 8'h02, 3'd1, 1'b0, "direct_a1");
        drv(1'b1, 1'b1, 1'b1, 3'd1, 4'd0, 8'h02, 3'd1, 1'b0, "scan_dn_entry");
        drv(1'b1, 1'b1, 1'b1, 3'd1, 4'd0, 8'h01, 3'd0, 1'b0, "scan_dn_0");
        drv(1'b1, 1'b1, 1'b1, 3'd1, 4'd0, 8'h80, 3'd7, 1'b1, "scan_dn_wrap7");
        drv(1'b1, 1'b1, 1'b1, 3'd1, 4'd0, 8'h40, 3'd6, 1'b0, "scan_dn_6");

        // Drop enable mid-scan: o_y off, index held.
        drv(1'b0, 1'b1, 1'b1, 3'd1, 4'd0, 8'h00, 3'd6, 1'b0, "idle_en_low");
        drv(1'b1, 1'b0, 1'b0, 3'd3, 4'd0, 8'h08, 3'd3, 1'b0, "direct_a3");

        // Re-enter scan at a=2, dwell 2; flip dir mid-dwell, takes effect at step.
        drv(1'b1, 1'b1, 1'b0, 3'd2, 4'd2, 8'h04, 3'd2, 1'b0, "rescan_entry2");
        drv(1'b1, 1'b1, 1'b1, 3'd5, 4'd2, 8'h04, 3'd2, 1'b0, "dir_flip_hold_a");
        drv(1'b1, 1'b1, 1'b1, 3'd5, 4'd2, 8'h04, 3'd2, 1'b0, "dir_flip_hold_b");
        drv(1'b1, 1'b1, 1'b1, 3'd5, 4'd2, 8'h02, 3'd1, 1'b0, "dir_flip_step");

        // Scan -> direct mid-dwell decodes i_a immediately.
        drv(1'b1, 1'b0, 1'b0, 3'd4, 4'd2, 8'h10, 3'd4, 1'b0, "direct_mid_dwell");

        // Scan at 7 with dwell 3, then async reset mid-dwell.
        drv(1'b1, 1'b1, 1'b0, 3'd7, 4'd3, 8'h80, 3'd7, 1'b0, "scan7_entry");
        drv(1'b1, 1'b1, 1'b0, 3'd7, 4'd3, 8'h80, 3'd7, 1'b0, "scan7_dwell");
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        compare("async_reset", {Y_INV, 3'd0, 1'b0});
        i_en = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // After reset, scan entry from IDLE then wrap up with dwell 0.
        drv(1'b1, 1'b1, 1'b0, 3'd7, 4'd0, 8'h80, 3'd7, 1'b0, "post_rst_entry");
        drv(1'b1, 1'b1, 1'b0, 3'd7, 4'd0, 8'h01, 3'd0, 1'b1, "post_rst_wrap");
        drv(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 8'h00, 3'd0, 1'b0, "final_idle");

        // Allow the monitor to drain, bounded.
        repeat (3) @(posedge i_clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_decoder_nsel_scan
